// File: rtl/d_mem_responder.sv
// Data-memory req/ack responder: word RAM answering after WAIT_CYCLES wait states, flagging misaligned/out-of-range accesses.
// Latency: ack in the cycle after capture edge + WAIT_CYCLES; inputs are held by the initiator and sampled only at capture.
module d_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [3:0]            cnt;
    logic [31:0]           cap_addr;
    logic                  cap_we;
    logic [DATA_WIDTH-1:0] cap_wdata;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic                  capture;
    logic                  commit;
    logic [31:0]           acc_addr;
    logic                  acc_we;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;

    // With zero wait states the commit edge is the capture edge, so the live inputs are used directly.
    always_comb begin
        acc_addr  = cap_addr;
        acc_we    = cap_we;
        acc_wdata = cap_wdata;
        if (state == S_IDLE) begin
            acc_addr  = addr;
            acc_we    = we;
            acc_wdata = wdata;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        acc_idx = acc_addr[ADDR_WIDTH+1:2];
    end

    assign capture = (state == S_IDLE) && req;
    assign commit  = (capture && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd1) state_nxt = S_RESP;
            end
            S_RESP: begin
                busy      = 1'b1;
                ack       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM contents deliberately survive reset; reset only blocks the write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            cap_addr  <= 32'd0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            if (capture) begin
                cap_addr  <= addr;
                cap_we    <= we;
                cap_wdata <= wdata;
                cnt       <= WAIT_CYCLES[3:0];
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                err   <= acc_err;
                rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
                if (acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
            end else if (state == S_RESP) begin
                err   <= 1'b0;
                rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance checked against a word-array model.
module tb_d_mem_responder;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_a, we_a, ack_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_a [DEPTH];
    bit          known_a [DEPTH];
    logic [31:0] model_b [DEPTH];
    bit          known_b [DEPTH];

    always #5 clock = ~clock;

    d_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a));

    d_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b));

    // Protocol invariants, sampled on the falling edge.
    logic prev_ack_a = 1'b0, prev_ack_b = 1'b0;
    always @(negedge clock) begin
        n_checks = n_checks + 3;
        if (ack_a === 1'b1 && prev_ack_a === 1'b1) begin n_fail++; $display("FAIL inv_ack_consec_a: ack high two cycles"); end
        if (ack_a === 1'b1 && busy_a !== 1'b1) begin n_fail++; $display("FAIL inv_ack_busy_a: busy=%b while ack=1, need 1", busy_a); end
        if (ack_a !== 1'b1 && err_a !== 1'b0) begin n_fail++; $display("FAIL inv_err_a: err=%b while ack=0, need 0", err_a); end
        n_checks = n_checks + 3;
        if (ack_b === 1'b1 && prev_ack_b === 1'b1) begin n_fail++; $display("FAIL inv_ack_consec_b: ack high two cycles"); end
        if (ack_b === 1'b1 && busy_b !== 1'b1) begin n_fail++; $display("FAIL inv_ack_busy_b: busy=%b while ack=1, need 1", busy_b); end
        if (ack_b !== 1'b1 && err_b !== 1'b0) begin n_fail++; $display("FAIL inv_err_b: err=%b while ack=0, need 0", err_b); end
        prev_ack_a = ack_a;
        prev_ack_b = ack_b;
    end

    // Reference: byte-addressed view of a word array; anything not word-aligned or beyond the array is an error.
    function automatic void model_txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                                      output logic e, output logic [31:0] rd, output bit known);
        int idx;
        e     = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
        rd    = 32'd0;
        known = 1'b1;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
                if (sel) begin model_b[idx] = d; known_b[idx] = 1'b1; end
                else     begin model_a[idx] = d; known_a[idx] = 1'b1; end
            end else begin
                rd    = sel ? model_b[idx] : model_a[idx];
                known = sel ? known_b[idx] : known_a[idx];
            end
        end
    endfunction

    // One transaction: lat = cycles from the capture edge to the edge after which ack is seen (-1 on timeout).
    task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
        int i;
        @(negedge clock);
        if (sel) begin req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d; end
        else     begin req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; end
        @(posedge clock); #1;
        req_a = 1'b0;
        req_b = 1'b0;
        lat = -1; rd = 32'd0; e = 1'b0; i = 0;
        while (lat < 0 && i < 20) begin
            if ((sel ? ack_b : ack_a) === 1'b1) begin
                lat = i;
                rd  = sel ? rdata_b : rdata_a;
                e   = sel ? err_b : err_a;
            end else begin
                @(posedge clock); #1;
                i++;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            req_a = k[0]; req_b = ~k[0]; we_a = 1'b1; we_b = 1'b1;
            addr_a = 32'h10; addr_b = 32'h10; wdata_a = 32'hFFFF_FFFF; wdata_b = 32'hFFFF_FFFF;
            @(posedge clock); #1;
            n_checks = n_checks + 4;
            if (ack_a !== 1'b0 || ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_ack: a=%b b=%b, need 0", ack_a, ack_b); end
            if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy: a=%b b=%b, need 0", busy_a, busy_b); end
            if (rdata_a !== 32'd0) begin n_fail++; $display("FAIL reset_rdata_a: got %h, need 0", rdata_a); end
            if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++; $display("FAIL reset_err: a=%b b=%b, need 0", err_a, err_b); end
        end
        @(negedge clock);
        req_a = 1'b0; req_b = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: busy a=%b b=%b, need 0", busy_a, busy_b); end
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic e, ee; logic [31:0] erd; bit kn;
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, e);
        model_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, ee, erd, kn);
        n_checks = n_checks + 3;
        if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d, need 2", lat); end
        if (e !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b, need 0", e); end
        if (rd !== 32'd0) begin n_fail++; $display("FAIL store_rdata: got %h, need 0", rd); end
        txn(0, 1'b0, 32'h10, 32'h0, lat, rd, e);
        model_txn(0, 1'b0, 32'h10, 32'h0, ee, erd, kn);
        n_checks = n_checks + 2;
        if (lat !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL load_lat_err: lat=%0d err=%b, need 2/0", lat, e); end
        if (rd !== erd) begin n_fail++; $display("FAIL load_rdata: got %h, need %h", rd, erd); end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic e, ee; logic [31:0] erd; bit kn;
        logic [31:0] av [6];
        logic        wv [6];
        logic [31:0] dv [6];
        // Misaligned store, then word 0 seeded, then an aliasing-looking store to 0x400, then top word.
        av = '{32'h12, 32'h10, 32'h0, 32'h400, 32'h0, 32'h3FC};
        wv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        dv = '{32'hBAD0_BAD0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h3333_3333};
        for (int k = 0; k < 6; k++) begin
            txn(0, wv[k], av[k], dv[k], lat, rd, e);
            model_txn(0, wv[k], av[k], dv[k], ee, erd, kn);
            n_checks = n_checks + 3;
            if (lat !== 2) begin n_fail++; $display("FAIL err_latency[%0d]: got %0d, need 2", k, lat); end
            if (e !== ee) begin n_fail++; $display("FAIL err_flag[%0d] addr=%h: got %b, need %b", k, av[k], e, ee); end
            if (rd !== erd) begin n_fail++; $display("FAIL err_rdata[%0d] addr=%h: got %h, need %h", k, av[k], rd, erd); end
        end
        txn(0, 1'b0, 32'h400, 32'h0, lat, rd, e);
        n_checks = n_checks + 1;
        if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_oob: err=%b rdata=%h, need 1/0", e, rd); end
        txn(0, 1'b0, 32'h3FC, 32'h0, lat, rd, e);
        n_checks = n_checks + 1;
        if (e !== 1'b0 || rd !== 32'h3333_3333) begin n_fail++; $display("FAIL load_top_word: err=%b rdata=%h, need 0/33333333", e, rd); end
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd; logic e, ee; logic [31:0] erd; bit kn;
        logic [31:0] a, d; logic w;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                1:       a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
                2:       a = 32'h8000_0000 | (32'($urandom_range(0, 15)) * 4);
                default: a = 32'($urandom_range(0, 15)) * 4;
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            txn(0, w, a, d, lat, rd, e);
            model_txn(0, w, a, d, ee, erd, kn);
            n_checks = n_checks + 2;
            if (lat !== 2) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d, need 2", k, lat); end
            if (e !== ee) begin n_fail++; $display("FAIL rand_err[%0d] addr=%h: got %b, need %b", k, a, e, ee); end
            if (kn) begin
                n_checks++;
                if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata[%0d] addr=%h we=%b: got %h, need %h", k, a, w, rd, erd); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int acks; int lat; logic [31:0] rd; logic e, ee; logic [31:0] erd; bit kn;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            req_b = 1'b1; we_b = 1'b1; addr_b = 32'h40; wdata_b = 32'h1000 + 32'(k);
            @(posedge clock); #1;
            if (k % 2 == 0) model_txn(1, 1'b1, 32'h40, 32'h1000 + 32'(k), ee, erd, kn);
            n_checks++;
            if (ack_b !== ((k % 2) == 0)) begin n_fail++; $display("FAIL b2b_ack_cycle[%0d]: got %b, need %b", k, ack_b, (k % 2) == 0); end
            if (ack_b === 1'b1) acks++;
        end
        @(negedge clock);
        req_b = 1'b0;
        n_checks++;
        if (acks !== 4) begin n_fail++; $display("FAIL b2b_ack_count: got %0d, need 4", acks); end
        txn(1, 1'b0, 32'h40, 32'h0, lat, rd, e);
        model_txn(1, 1'b0, 32'h40, 32'h0, ee, erd, kn);
        n_checks = n_checks + 2;
        if (lat !== 0) begin n_fail++; $display("FAIL b2b_zero_wait_latency: got %0d, need 0", lat); end
        if (rd !== erd || e !== 1'b0) begin n_fail++; $display("FAIL b2b_last_store: rdata=%h err=%b, need %h/0", rd, e, erd); end
    endtask

    task automatic test_reset_mid_wait;
        int lat; logic [31:0] rd; logic e, ee; logic [31:0] erd; bit kn;
        txn(0, 1'b1, 32'h20, 32'hCAFE_F00D, lat, rd, e);
        model_txn(0, 1'b1, 32'h20, 32'hCAFE_F00D, ee, erd, kn);
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h1234_5678;
        @(posedge clock); #1;
        req_a = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            n_checks++;
            if (ack_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack[%0d]: ack=%b busy=%b, need 0/0", k, ack_a, busy_a); end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            n_checks++;
            if (ack_a !== 1'b0) begin n_fail++; $display("FAIL abort_late_ack[%0d]: got %b, need 0", k, ack_a); end
        end
        txn(0, 1'b0, 32'h20, 32'h0, lat, rd, e);
        model_txn(0, 1'b0, 32'h20, 32'h0, ee, erd, kn);
        n_checks++;
        if (rd !== erd || lat !== 2) begin n_fail++; $display("FAIL abort_prior_value: rdata=%h lat=%0d, need %h/2", rd, lat, erd); end
    endtask

    task automatic test_churn;
        int acks; logic [31:0] got; logic e, ee; logic [31:0] erd; bit kn;
        int lat; logic [31:0] rd;
        acks = 0; got = 32'd0;
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h20; wdata_a = 32'h0;
        @(posedge clock); #1;
        model_txn(0, 1'b0, 32'h20, 32'h0, ee, erd, kn);
        for (int k = 0; k < 8; k++) begin
            if (ack_a === 1'b1) begin acks++; got = rdata_a; end
            @(negedge clock);
            req_a = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1)) & (k < 2);
            we_a = 1'b1; addr_a = $urandom & 32'h3FC; wdata_a = $urandom;
            @(posedge clock); #1;
            req_a = 1'b0;
        end
        n_checks = n_checks + 2;
        if (acks !== 1) begin n_fail++; $display("FAIL churn_ack_count: got %0d, need 1", acks); end
        if (got !== erd) begin n_fail++; $display("FAIL churn_captured_load: got %h, need %h", got, erd); end
        txn(0, 1'b0, 32'h20, 32'h0, lat, rd, e);
        model_txn(0, 1'b0, 32'h20, 32'h0, ee, erd, kn);
        n_checks++;
        if (rd !== erd) begin n_fail++; $display("FAIL churn_no_stray_store: got %h, need %h", rd, erd); end
    endtask

    initial begin
        req_a = 1'b0; we_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 32'd0; wdata_b = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            known_a[i] = 1'b0; known_b[i] = 1'b0; model_a[i] = 32'd0; model_b[i] = 32'd0;
        end
        test_reset;
        test_store_load;
        test_errors;
        test_random;
        test_back_to_back;
        test_reset_mid_wait;
        test_churn;
        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
